// File: rtl/vga_pkg.sv
// Purpose: shared VGA frame geometry, pixel bundle and scheduler state encoding.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a. Imported by the frame scheduler and by the draw engines.
package vga_pkg;

    localparam int H_RES = 160;
    localparam int V_RES = 120;
    localparam int XW    = 8;
    localparam int YW    = 7;
    localparam int CW    = 3;

    localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DRAW  = 2'd2
    } state_e;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [CW-1:0] colour;
    } pix_t;

    // True when the pixel lands inside the visible buffer.
    function automatic logic on_screen(input pix_t p);
        return (p.x <= X_LAST) && (p.y <= Y_LAST);
    endfunction

endpackage

// File: rtl/frame_plot_scheduler_if.sv
// Purpose: pixel bus between two draw requesters, the frame scheduler and vga_adapter.
// Latency: n/a (wires only).
// Backpressure: reqN_ready is the scheduler's accept; x/y/colour/plot have none.
// Ports: reqN_valid/x/y/colour/done from requesters, reqN_ready back to them,
//        x/y/colour/plot out to the vga_adapter write port.
interface frame_plot_scheduler_if;
    import vga_pkg::*;

    logic          req0_valid;
    logic [XW-1:0] req0_x;
    logic [YW-1:0] req0_y;
    logic [CW-1:0] req0_colour;
    logic          req0_done;
    logic          req0_ready;

    logic          req1_valid;
    logic [XW-1:0] req1_x;
    logic [YW-1:0] req1_y;
    logic [CW-1:0] req1_colour;
    logic          req1_done;
    logic          req1_ready;

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] colour;
    logic          plot;

    // Scheduler side.
    modport slave (
        input  req0_valid, req0_x, req0_y, req0_colour, req0_done,
        input  req1_valid, req1_x, req1_y, req1_colour, req1_done,
        output req0_ready, req1_ready,
        output x, y, colour, plot
    );

    // Requester / display side.
    modport master (
        output req0_valid, req0_x, req0_y, req0_colour, req0_done,
        output req1_valid, req1_x, req1_y, req1_colour, req1_done,
        input  req0_ready, req1_ready,
        input  x, y, colour, plot
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Purpose: two-way round-robin grant; favoured requester flips only on an accepted transfer.
// Latency: combinational grant, pointer updates at the clock edge after an accept.
// Backpressure: a stalled (not enabled) cycle leaves the pointer untouched.
// Ports: clk, reset (sync, active-high), en_i (grants are being consumed),
//        valid0_i/valid1_i requests, grant0_o/grant1_o one-hot-or-zero grants.
module rr_arbiter2 (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic valid0_i,
    input  logic valid1_i,
    output logic grant0_o,
    output logic grant1_o
);

    // ptr_q names the requester that wins when both are valid.
    logic ptr_q, ptr_d;

    assign grant0_o = valid0_i & (~valid1_i | ~ptr_q);
    assign grant1_o = valid1_i & (~valid0_i |  ptr_q);

    always_comb begin
        ptr_d = ptr_q;
        if (en_i && grant0_o) begin
            ptr_d = 1'b1;
        end else if (en_i && grant1_o) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/frame_plot_scheduler.sv
// Purpose: per 60 Hz tick, clear the 160x120 buffer then round-robin two draw requesters onto the plot port.
// Latency: one cycle from clear-counter step or accepted pixel to registered x/y/colour/plot.
// Backpressure: requesters only see ready in DRAW; off-screen pixels are accepted and dropped.
// Ports: clock50MHz, reset (sync, active-high), clock60Hz tick level, bg_colour,
//        bus (slave side of the pixel interface), frame_start, busy, frame_overrun.
module frame_plot_scheduler
    import vga_pkg::*;
(
    input  logic                    clock50MHz,
    input  logic                    reset,
    input  logic                    clock60Hz,
    input  logic [CW-1:0]           bg_colour,
    frame_plot_scheduler_if.slave   bus,
    output logic                    frame_start,
    output logic                    busy,
    output logic                    frame_overrun
);

    state_e        state_q, state_d;
    logic          tick_q;
    logic          tick_edge;
    logic [XW-1:0] cx_q, cx_d;
    logic [YW-1:0] cy_q, cy_d;
    logic [CW-1:0] bg_q, bg_d;
    pix_t          pix_q, pix_d;
    logic          plot_q, plot_d;
    logic          entry_q, entry_d;   // first DRAW cycle; frame_start follows it
    logic          fs_q, fs_d;
    logic          busy_q, busy_d;
    logic          ovr_q, ovr_d;
    logic          done0_q, done0_d;
    logic          done1_q, done1_d;
    logic          grant0, grant1;
    logic          in_draw;
    pix_t          req0_pix, req1_pix;

    assign tick_edge = clock60Hz & ~tick_q;
    assign in_draw   = (state_q == ST_DRAW);

    assign req0_pix = '{x: bus.req0_x, y: bus.req0_y, colour: bus.req0_colour};
    assign req1_pix = '{x: bus.req1_x, y: bus.req1_y, colour: bus.req1_colour};

    rr_arbiter2 u_arb (
        .clk      (clock50MHz),
        .reset    (reset),
        .en_i     (in_draw),
        .valid0_i (bus.req0_valid),
        .valid1_i (bus.req1_valid),
        .grant0_o (grant0),
        .grant1_o (grant1)
    );

    assign bus.req0_ready = in_draw & bus.req0_valid & grant0;
    assign bus.req1_ready = in_draw & bus.req1_valid & grant1;

    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        bg_d    = bg_q;
        pix_d   = pix_q;
        plot_d  = 1'b0;
        entry_d = 1'b0;
        fs_d    = entry_q;
        done0_d = done0_q;
        done1_d = done1_q;
        // A tick while a frame is still running is dropped, only flagged.
        ovr_d   = ovr_q | (tick_edge & (state_q != ST_IDLE));

        case (state_q)
            ST_IDLE: begin
                if (tick_edge) begin
                    bg_d    = bg_colour;
                    cx_d    = '0;
                    cy_d    = '0;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                plot_d = 1'b1;
                pix_d  = '{x: cx_q, y: cy_q, colour: bg_q};
                if (cx_q == X_LAST) begin
                    cx_d = '0;
                    if (cy_q == Y_LAST) begin
                        state_d = ST_DRAW;
                        entry_d = 1'b1;
                        done0_d = 1'b0;
                        done1_d = 1'b0;
                    end else begin
                        cy_d = cy_q + 1'b1;
                    end
                end else begin
                    cx_d = cx_q + 1'b1;
                end
            end
            ST_DRAW: begin
                if (bus.req0_ready) begin
                    if (on_screen(req0_pix)) begin
                        plot_d = 1'b1;
                        pix_d  = req0_pix;
                    end
                end else if (bus.req1_ready) begin
                    if (on_screen(req1_pix)) begin
                        plot_d = 1'b1;
                        pix_d  = req1_pix;
                    end
                end
                done0_d = done0_q | bus.req0_done;
                done1_d = done1_q | bus.req1_done;
                if (done0_d && done1_d) begin
                    state_d = ST_IDLE;
                    done0_d = 1'b0;
                    done1_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock50MHz) begin
        if (reset) begin
            state_q <= ST_IDLE;
            tick_q  <= 1'b0;
            cx_q    <= '0;
            cy_q    <= '0;
            bg_q    <= '0;
            pix_q   <= '0;
            plot_q  <= 1'b0;
            entry_q <= 1'b0;
            fs_q    <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= clock60Hz;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            bg_q    <= bg_d;
            pix_q   <= pix_d;
            plot_q  <= plot_d;
            entry_q <= entry_d;
            fs_q    <= fs_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
        end
    end

    assign bus.x         = pix_q.x;
    assign bus.y         = pix_q.y;
    assign bus.colour    = pix_q.colour;
    assign bus.plot      = plot_q;
    assign frame_start   = fs_q;
    assign busy          = busy_q;
    assign frame_overrun = ovr_q;

endmodule
